xor_mux_parity_serial: RTL and testbench
========================================

Name: xor_mux_parity_serial

Overview:
- Serial parity engine built from 2:1 mux XOR cells.
- Each cell computes acc_next = bit ? ~acc : acc.
- Accepts WIDTH-bit words over a valid/ready handshake and folds them BITS_PER_CYCLE bits per clock into a running parity.
- Accumulates across a multi-word frame terminated by in_last, then presents even/odd parity and a word count on an output handshake.
- Sits between a word source and a checker/packetiser in the combinational-logic exercise family, as its sequential, parametrised successor.

Parameters:
- WIDTH, 8, data word width; must be >= 2.
- BITS_PER_CYCLE, 1, bits folded per clock; must divide WIDTH.
- CNT_W, 8, width of the frame word counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  engine can accept a word
- in_data  input  WIDTH  word to fold
- in_last  input  1  word is last of frame; sampled with the handshake
- odd_mode  input  1  1 = odd parity; sampled on the first word of a frame only
- out_valid  output  1  frame result valid
- out_ready  input  1  consumer accepts the result
- out_parity  output  1  frame parity (XOR of all bits, XOR odd_mode)
- out_count  output  CNT_W  number of words in the frame; saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0, out_parity = 0, out_count = 0
  - accumulator = 0, shift register = 0, frame-start flag = 1
- N = WIDTH / BITS_PER_CYCLE shift cycles per word.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load in_data into the shift register, latch in_last, and increment the word count.
  - If the frame-start flag is set, latch odd_mode and clear the flag.
  - Transition to SHIFT with a remaining-bit counter of N.
- SHIFT:
  - in_ready = 0.
  - Each clock, fold the BITS_PER_CYCLE LSBs into the accumulator through a chain of mux XOR cells, shift right by BITS_PER_CYCLE, and decrement the counter.
  - On the edge where the counter reaches 0: go to DONE if the latched last is set, otherwise return to IDLE with the accumulator retained.
- DONE:
  - out_valid = 1.
  - out_parity = accumulator XOR latched odd_mode.
  - out_count = word count.
  - out_parity and out_count are stable while out_valid is high.
  - On out_ready: clear out_valid, the accumulator and the word count; set the frame-start flag; return to IDLE.
- Latency: out_valid rises exactly N clocks after the accepting edge of the last word.
- Back-to-back words: the next word can be accepted at the earliest 1 clock after SHIFT ends, i.e. throughput is one word per N+1 clocks.
- in_ready is 0 in SHIFT and DONE. A word offered then is held by the source, never dropped.
- out_count saturates at 2^CNT_W - 1 and does not wrap. Parity remains exact regardless of saturation.
- odd_mode changes mid-frame are ignored.
- in_last with a single word is a one-word frame.
- out_ready asserted while out_valid = 0 has no effect.
- Reset mid-operation: any state returns immediately to reset values and the in-flight frame is discarded. The first word after rst_n deasserts starts a new frame.

Optional Feature:
- Macro: XOR_MUX_PARITY_CHECK_EN.
- When defined:
  - Adds input in_check (1 bit), sampled with the last word's handshake.
  - Adds output out_error (1 bit), valid with out_valid: out_error = out_parity XOR in_check.
  - out_error resets to 0 and clears with the out handshake.
- When undefined: neither port exists and the behaviour is otherwise identical.

Test Plan:
- WIDTH=8, BPC=1: send 8'hA5, in_last=1, odd_mode=0 → out_valid exactly 8 clocks after the handshake, out_parity=0, out_count=1.
- Frame 8'h01, 8'h03, 8'hFF (last), odd_mode=0 → out_parity=1 (11 ones), out_count=3. in_ready=0 during each SHIFT and high in IDLE between words.
- odd_mode=1 on the first word 8'h00, toggled to 0 on the second word 8'h00 (last) → out_parity=1, confirming odd_mode is sampled only once.
- Hold out_ready=0 for 5 clocks in DONE → out_valid, out_parity and out_count stable; in_valid held high is not accepted (in_ready=0). Release out_ready → back to IDLE the next clock.
- Pull rst_n low 3 clocks into SHIFT → all outputs at reset values immediately. A new one-word frame 8'h07 then yields out_parity=1, out_count=1.
- WIDTH=8, BPC=4: send 8'hF1 (last) → latency 2 clocks, out_parity=1. With CNT_W=2, a 5-word frame → out_count=3 (saturated).

Source files
------------

// File: rtl/xor_mux_parity_serial.sv
// Serial frame-parity engine: folds WIDTH-bit words BITS_PER_CYCLE bits per clock through mux XOR cells.
// Optional parity-check port pair (in_check/out_error) is enabled by defining XOR_MUX_PARITY_CHECK_EN.
module xor_mux_parity_serial #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             odd_mode,
`ifdef XOR_MUX_PARITY_CHECK_EN
  input  logic             in_check,
  output logic             out_error,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned REM_W = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_shift, w_shift_d;
  logic [REM_W-1:0] r_rem, w_rem_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_acc, w_acc_d;
  logic             r_last, w_last_d;
  logic             r_odd, w_odd_d;
  logic             r_first, w_first_d;
  logic             w_fold;
`ifdef XOR_MUX_PARITY_CHECK_EN
  logic             r_check, w_check_d;
`endif

  // Chain of 2:1 mux XOR cells: each set bit inverts the running parity.
  always_comb begin
    w_fold = r_acc;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      w_fold = r_shift[i] ? ~w_fold : w_fold;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_rem_d   = r_rem;
    w_cnt_d   = r_cnt;
    w_acc_d   = r_acc;
    w_last_d  = r_last;
    w_odd_d   = r_odd;
    w_first_d = r_first;
`ifdef XOR_MUX_PARITY_CHECK_EN
    w_check_d = r_check;
`endif
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_shift_d = in_data;
          w_last_d  = in_last;
          w_rem_d   = REM_W'(N);
          w_state_d = StShift;
          if (r_cnt != {CNT_W{1'b1}}) w_cnt_d = r_cnt + CNT_W'(1);
          if (r_first) begin
            w_odd_d   = odd_mode;
            w_first_d = 1'b0;
          end
`ifdef XOR_MUX_PARITY_CHECK_EN
          if (in_last) w_check_d = in_check;
`endif
        end
      end
      StShift: begin
        w_acc_d   = w_fold;
        w_shift_d = r_shift >> BITS_PER_CYCLE;
        w_rem_d   = r_rem - REM_W'(1);
        if (r_rem == REM_W'(1)) w_state_d = r_last ? StDone : StIdle;
      end
      StDone: begin
        if (out_ready) begin
          w_acc_d   = 1'b0;
          w_cnt_d   = '0;
          w_first_d = 1'b1;
          w_state_d = StIdle;
`ifdef XOR_MUX_PARITY_CHECK_EN
          w_check_d = 1'b0;
`endif
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_acc   <= 1'b0;
      r_last  <= 1'b0;
      r_odd   <= 1'b0;
      r_first <= 1'b1;
`ifdef XOR_MUX_PARITY_CHECK_EN
      r_check <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_shift <= w_shift_d;
      r_rem   <= w_rem_d;
      r_cnt   <= w_cnt_d;
      r_acc   <= w_acc_d;
      r_last  <= w_last_d;
      r_odd   <= w_odd_d;
      r_first <= w_first_d;
`ifdef XOR_MUX_PARITY_CHECK_EN
      r_check <= w_check_d;
`endif
    end
  end

  // Outputs are gated by DONE so they read as zero outside a presented result.
  assign in_ready   = (r_state == StIdle);
  assign out_valid  = (r_state == StDone);
  assign out_parity = out_valid & (r_acc ^ r_odd);
  assign out_count  = out_valid ? r_cnt : '0;
`ifdef XOR_MUX_PARITY_CHECK_EN
  assign out_error  = out_valid & (r_acc ^ r_odd ^ r_check);
`endif

endmodule

// File: tb/tb_xor_mux_parity_serial.sv
// Scoreboard bench for xor_mux_parity_serial: dut0 is WIDTH=8/BPC=1/CNT_W=8, dut1 is WIDTH=8/BPC=4/CNT_W=2.
// Also exercises the XOR_MUX_PARITY_CHECK_EN ports when that macro is defined.
module tb_xor_mux_parity_serial;

  typedef struct {
    logic par;
    logic err;
    int   cnt;
    int   cyc;
  } exp_t;

  logic       clk, rst_n;
  logic       in_valid, sel;
  logic [7:0] in_data;
  logic       in_last, odd_mode, out_ready, in_check;
  logic       in_valid0, in_ready0, out_valid0, out_parity0;
  logic       in_valid1, in_ready1, out_valid1, out_parity1;
  logic [7:0] out_count0;
  logic [1:0] out_count1;
`ifdef XOR_MUX_PARITY_CHECK_EN
  logic       out_error0, out_error1;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise0 = 0;
  int   rise1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  assign in_valid0 = in_valid & ~sel;
  assign in_valid1 = in_valid & sel;

  xor_mux_parity_serial #(.WIDTH(8), .BITS_PER_CYCLE(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data),
    .in_last(in_last), .odd_mode(odd_mode),
`ifdef XOR_MUX_PARITY_CHECK_EN
    .in_check(in_check), .out_error(out_error0),
`endif
    .out_valid(out_valid0), .out_ready(out_ready), .out_parity(out_parity0),
    .out_count(out_count0)
  );

  xor_mux_parity_serial #(.WIDTH(8), .BITS_PER_CYCLE(4), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data),
    .in_last(in_last), .odd_mode(odd_mode),
`ifdef XOR_MUX_PARITY_CHECK_EN
    .in_check(in_check), .out_error(out_error1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready), .out_parity(out_parity1),
    .out_count(out_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [7:0] d, input logic last, input logic odd,
                           input logic ep, input int ec);
    int   t;
    exp_t e;
    t = 0;
    in_valid = 1'b1; in_data = d; in_last = last; odd_mode = odd;
    while (!(sel ? in_ready1 : in_ready0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!(sel ? in_ready1 : in_ready0)) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (last) begin
      e.par = ep; e.err = ep ^ in_check; e.cnt = ec; e.cyc = cyc;
      if (sel) q1.push_back(e);
      else q0.push_back(e);
    end
    @(negedge clk);
    check("busy_in_shift", {31'd0, (sel ? in_ready1 : in_ready0)}, 32'd0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q0.size() + q1.size());
    end
    @(negedge clk);
  endtask

  initial begin : mon0
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev = 1'b0;
      else begin
        if (out_valid0 && !prev) rise0 = cyc;
        if (out_valid0 && out_ready) begin
          if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL d0_unexpected: result parity=%0d count=%0d, required none",
                     out_parity0, out_count0);
          end else begin
            e = q0.pop_front();
            check("d0_parity", {31'd0, out_parity0}, {31'd0, e.par});
            check("d0_count", {24'd0, out_count0}, e.cnt);
            check("d0_latency", rise0 - e.cyc, 32'd8);
`ifdef XOR_MUX_PARITY_CHECK_EN
            check("d0_error", {31'd0, out_error0}, {31'd0, e.err});
`endif
          end
        end
        prev = out_valid0;
      end
    end
  end

  initial begin : mon1
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev = 1'b0;
      else begin
        if (out_valid1 && !prev) rise1 = cyc;
        if (out_valid1 && out_ready) begin
          if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL d1_unexpected: result parity=%0d count=%0d, required none",
                     out_parity1, out_count1);
          end else begin
            e = q1.pop_front();
            check("d1_parity", {31'd0, out_parity1}, {31'd0, e.par});
            check("d1_count", {30'd0, out_count1}, e.cnt);
            check("d1_latency", rise1 - e.cyc, 32'd2);
`ifdef XOR_MUX_PARITY_CHECK_EN
            check("d1_error", {31'd0, out_error1}, {31'd0, e.err});
`endif
          end
        end
        prev = out_valid1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t;
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; in_data = '0; in_last = 1'b0;
    odd_mode = 1'b0; out_ready = 1'b1; in_check = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_d0", {in_ready0, out_valid0, out_parity0, out_count0}, {3'b100, 8'd0});
    check("reset_d1", {in_ready1, out_valid1, out_parity1, out_count1}, {3'b100, 2'd0});
    rst_n = 1'b1;

    // One-word frame 0xA5: four ones, even parity.
    send_word(8'hA5, 1'b1, 1'b0, 1'b0, 1);

    // Three-word frame, 11 ones in total.
    send_word(8'h01, 1'b0, 1'b0, 1'b0, 0);
    repeat (8) @(negedge clk);
    check("idle_between_words", {31'd0, in_ready0}, 32'd1);
    send_word(8'h03, 1'b0, 1'b0, 1'b0, 0);
    send_word(8'hFF, 1'b1, 1'b0, 1'b1, 3);

    // odd_mode taken from the first word only.
    in_check = 1'b1;
    send_word(8'h00, 1'b0, 1'b1, 1'b0, 0);
    send_word(8'h00, 1'b1, 1'b0, 1'b1, 2);
    in_check = 1'b0;

    // Back-pressure in DONE with a word waiting at the input.
    drain();
    out_ready = 1'b0;
    send_word(8'h3C, 1'b1, 1'b0, 1'b0, 1);
    in_valid = 1'b1; in_data = 8'h03; in_last = 1'b1; odd_mode = 1'b0;
    t = 0;
    while (!out_valid0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_stable", {out_valid0, out_parity0, out_count0, in_ready0},
            {2'b10, 8'd1, 1'b0});
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_after_release", {31'd0, in_ready0}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.par = 1'b0; e.err = 1'b0; e.cnt = 1; e.cyc = cyc;
    q0.push_back(e);
    @(negedge clk);

    // Asynchronous reset in the middle of SHIFT discards the in-flight word.
    drain();
    send_word(8'h01, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_shift", {in_ready0, out_valid0, out_parity0, out_count0}, {3'b100, 8'd0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_word(8'h07, 1'b1, 1'b0, 1'b1, 1);

    // Four bits per clock, then a five-word frame saturating the two-bit counter.
    drain();
    sel = 1'b1;
    send_word(8'hF1, 1'b1, 1'b0, 1'b1, 1);
    send_word(8'h01, 1'b0, 1'b1, 1'b0, 0);
    send_word(8'h02, 1'b0, 1'b0, 1'b0, 0);
    send_word(8'h04, 1'b0, 1'b0, 1'b0, 0);
    send_word(8'h08, 1'b0, 1'b0, 1'b0, 0);
    send_word(8'h10, 1'b1, 1'b0, 1'b0, 3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
